vehicle_detect: RTL and testbench
=================================

// Module: vehicle_detect
// PURPOSE
//  Front end for the side-road request X consumed by sig_control.
//  - Synchronises the raw loop-sensor level into `clock`, then debounces it.
//  - Confirms vehicle arrival and departure.
//  - Drives X with a post-departure hold so the controller sees a clean, glitch-free request.
//  - Also counts confirmed vehicles and flags a stuck sensor.
// PARAMETERS
//  DEBOUNCE_CYCLES  4     consecutive equal synced samples needed to confirm arrival/departure (>=2)
//  HOLD_CYCLES      8     cycles X stays high after confirmed departure (0 = no hold)
//  STUCK_CYCLES     1000  cycles in PRESENT before fault is raised (>=1)
//  CNT_W            8     width of veh_count
// PORTS
//  clock       in   1      system clock, all logic on posedge
//  clear       in   1      synchronous active-high reset
//  sensor_raw  in   1      asynchronous loop-sensor level, 1 = metal detected
//  enable      in   1      0 forces X low (maintenance); detection and counting continue
//  X           out  1      registered vehicle request to sig_control
//  veh_count   out  CNT_W  confirmed arrivals, saturating
//  fault       out  1      sticky stuck-sensor flag
// BEHAVIOUR
//  Reset
//   - clear=1 at a posedge: state=IDLE; X=0; veh_count=0; fault=0.
//   - Synchroniser flops and all counters go to 0.
//   - clear wins over every other input, including mid-debounce or mid-hold.
//  Synchroniser
//   - s1<=sensor_raw, s2<=s1. Only s2 is used by the FSM.
//  FSM states: IDLE, ARRIVE, PRESENT, DEPART, HOLD. One debounce counter (dcnt), one hold counter, one stuck counter.
//   - IDLE:    s2=1 -> ARRIVE, dcnt=1.
//   - ARRIVE:  s2=0 -> IDLE, X=0.
//              s2=1 and dcnt==DEBOUNCE_CYCLES-1 -> PRESENT, veh_count+1 (saturating).
//              Otherwise dcnt++.
//   - PRESENT: s2=0 -> DEPART, dcnt=1. Otherwise the stuck counter increments.
//   - DEPART:  s2=1 -> PRESENT (glitch; no recount; stuck counter not reset).
//              s2=0 and dcnt==DEBOUNCE_CYCLES-1 -> HOLD, or -> IDLE if HOLD_CYCLES==0.
//              Otherwise dcnt++.
//   - HOLD:    s2=1 -> ARRIVE, dcnt=1; X kept high.
//              Hold counter reaches HOLD_CYCLES-1 -> IDLE.
//              Otherwise hold counter++.
//  Stuck counter
//   - Cleared on every entry to PRESENT from ARRIVE.
//   - On reaching STUCK_CYCLES: fault<=1 (sticky until clear); counter saturates.
//  X rules (registered, updated with state)
//   - X=1 on entry to PRESENT, DEPART, HOLD.
//   - X=0 on entry to IDLE.
//   - X unchanged while in ARRIVE.
//   - enable=0 forces X=0 at the next edge; FSM and counters are unaffected.
//   - fault does not alter X (fail-safe: stuck-occupied keeps serving the side road).
//  Latency
//   - Counting edge 1 as the first posedge sampling sensor_raw=1, X rises at edge DEBOUNCE_CYCLES+2.
//   - Fall: X drops DEBOUNCE_CYCLES+HOLD_CYCLES+2 edges after sensor_raw is first sampled 0.
//  Widths
//   - dcnt, hold and stuck counters sized with $clog2 of their parameter (+1). No wrap-around anywhere.
//   - veh_count holds at all-ones.
// TESTING (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, STUCK_CYCLES=20, CNT_W=8)
//  1. clear for 2 cycles, sensor_raw=0 -> X=0, veh_count=0, fault=0.
//  2. sensor_raw 0->1 held 30 cycles, then 0 held 30 cycles.
//     -> X rises at edge 6; veh_count=1; X falls 14 edges after release.
//  3. sensor_raw high for 3 cycles in IDLE -> X stays 0, veh_count stays 0.
//  4. In PRESENT, sensor_raw dropped for 2 cycles -> X stays 1, veh_count unchanged.
//  5. Second vehicle arrives during HOLD.
//     -> X never drops; veh_count=2; X drops 14 edges after the second release.
//  6. enable=0 while present -> X=0 next edge while veh_count still counts.
//     Also: sensor held 1 for 40 cycles -> fault=1 stays set until clear.
//     Also: 300 short arrivals -> veh_count saturates at 255.

Source files
------------

// File: rtl/vehicle_detect.sv
// rtl/vehicle_detect.sv - side-road vehicle request front end: sync, debounce, hold, count, stuck flag
`timescale 1ns/1ps
module vehicle_detect #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8,
    parameter int STUCK_CYCLES    = 1000,
    parameter int CNT_W           = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             sensor_raw,
    input  logic             enable,
    output logic             X,
    output logic [CNT_W-1:0] veh_count,
    output logic             fault
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [SW-1:0] S_MAX  = SW'(STUCK_CYCLES);

    typedef enum logic [2:0] {IDLE, ARRIVE, PRESENT, DEPART, HOLD} state_t;

    state_t          state, state_nx;
    logic            s1, s2;
    logic [DW-1:0]   dcnt, dcnt_nx;
    logic [HW-1:0]   hcnt, hcnt_nx;
    logic [SW-1:0]   scnt, scnt_nx;
    logic            x_req, x_req_nx;
    logic            cnt_inc;

    always_ff @(posedge clock) begin
        if (clear) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= IDLE;
            dcnt      <= '0;
            hcnt      <= '0;
            scnt      <= '0;
            x_req     <= 1'b0;
            X         <= 1'b0;
            veh_count <= '0;
            fault     <= 1'b0;
        end else begin
            s1    <= sensor_raw;
            s2    <= s1;
            state <= state_nx;
            dcnt  <= dcnt_nx;
            hcnt  <= hcnt_nx;
            scnt  <= scnt_nx;
            x_req <= x_req_nx;
            // x_req follows the detection rules; enable only gates what leaves the block
            X     <= enable & x_req_nx;
            if (cnt_inc && veh_count != {CNT_W{1'b1}})
                veh_count <= veh_count + 1'b1;
            if (scnt_nx == S_MAX)
                fault <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        hcnt_nx  = hcnt;
        scnt_nx  = scnt;
        x_req_nx = x_req;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nx = ARRIVE;
                    dcnt_nx  = D_ONE;
                end
            end
            ARRIVE: begin
                if (!s2) begin
                    state_nx = IDLE;
                    x_req_nx = 1'b0;
                end else if (dcnt == D_LAST) begin
                    state_nx = PRESENT;
                    x_req_nx = 1'b1;
                    cnt_inc  = 1'b1;
                    scnt_nx  = '0;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            PRESENT: begin
                if (!s2) begin
                    state_nx = DEPART;
                    dcnt_nx  = D_ONE;
                    x_req_nx = 1'b1;
                end else if (scnt != S_MAX) begin
                    scnt_nx = scnt + 1'b1;
                end
            end
            DEPART: begin
                if (s2) begin
                    state_nx = PRESENT;
                    x_req_nx = 1'b1;
                end else if (dcnt == D_LAST) begin
                    if (HOLD_CYCLES == 0) begin
                        state_nx = IDLE;
                        x_req_nx = 1'b0;
                    end else begin
                        state_nx = HOLD;
                        hcnt_nx  = '0;
                        x_req_nx = 1'b1;
                    end
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
            end
            HOLD: begin
                // a new arrival during hold keeps X up while it is being confirmed
                if (s2) begin
                    state_nx = ARRIVE;
                    dcnt_nx  = D_ONE;
                end else if (hcnt == H_LAST) begin
                    state_nx = IDLE;
                    x_req_nx = 1'b0;
                end else begin
                    hcnt_nx = hcnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                x_req_nx = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_vehicle_detect.sv
// tb/tb_vehicle_detect.sv - self-checking bench for vehicle_detect against a run-length reference model
`timescale 1ns/1ps
module tb_vehicle_detect;
    localparam int D = 4;
    localparam int H = 8;
    localparam int S = 20;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         sensor_raw = 1'b0;
    logic         enable = 1'b1;
    logic         X;
    logic [W-1:0] veh_count;
    logic         fault;

    always #5 clock = ~clock;

    vehicle_detect #(
        .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .STUCK_CYCLES(S), .CNT_W(W)
    ) dut (
        .clock(clock), .clear(clear), .sensor_raw(sensor_raw), .enable(enable),
        .X(X), .veh_count(veh_count), .fault(fault)
    );

    int    checks = 0;
    int    failures = 0;
    string phase = "reset";

    // reference model: raw delay line, debounced occupancy, run lengths, hold timer
    int m_r1, m_r2, m_occ, m_ones, m_zeros, m_hold, m_xreq, m_stuck, m_cnt, m_fault, m_x;

    function automatic void model_reset();
        m_r1 = 0; m_r2 = 0; m_occ = 0; m_ones = 0; m_zeros = 0; m_hold = 0;
        m_xreq = 0; m_stuck = 0; m_cnt = 0; m_fault = 0; m_x = 0;
    endfunction

    function automatic void model_edge(input int raw, input int en, input int clr);
        int s;
        if (clr != 0) begin
            model_reset();
            return;
        end
        s = m_r2;
        m_r2 = m_r1;
        m_r1 = raw;
        if (m_occ == 0) begin
            if (s != 0) begin
                m_ones++;
                m_hold = 0;
                if (m_ones == D) begin
                    m_occ = 1; m_ones = 0; m_zeros = 0; m_xreq = 1; m_stuck = 0;
                    if (m_cnt < (1 << W) - 1) m_cnt++;
                end
            end else if (m_ones > 0) begin
                m_ones = 0; m_xreq = 0; m_hold = 0;
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) m_xreq = 0;
            end
        end else begin
            if (s != 0) begin
                if (m_zeros == 0 && m_stuck < S) m_stuck++;
                m_zeros = 0;
            end else begin
                m_zeros++;
                if (m_zeros == D) begin
                    m_occ = 0; m_zeros = 0; m_ones = 0; m_hold = H;
                    m_xreq = (H > 0) ? 1 : 0;
                end
            end
        end
        if (m_stuck >= S) m_fault = 1;
        m_x = en & m_xreq;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s: observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic step(input logic raw, input logic en, input logic clr);
        sensor_raw = raw;
        enable     = en;
        clear      = clr;
        @(posedge clock);
        model_edge(int'(raw), int'(en), int'(clr));
        #1;
        check("X", {31'b0, X}, m_x[31:0]);
        check("veh_count", {24'b0, veh_count}, m_cnt[31:0]);
        check("fault", {31'b0, fault}, m_fault[31:0]);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int first;
        int seen;
        int lvl;
        int run;
        int cyc;
        model_reset();

        phase = "reset";
        do_clear();
        check("reset_X", {31'b0, X}, 32'd0);
        check("reset_count", {24'b0, veh_count}, 32'd0);
        check("reset_fault", {31'b0, fault}, 32'd0);

        phase = "single";
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (first < 0 && X === 1'b1) first = i;
        end
        check("rise_edge", first, 32'd6);
        check("count_one", {24'b0, veh_count}, 32'd1);
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (first < 0 && X === 1'b0) first = i;
        end
        check("fall_edge", first, 32'd14);

        phase = "short_pulse";
        do_clear();
        seen = 0;
        for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1, 1'b0); if (X !== 1'b0) seen = 1; end
        for (int i = 0; i < 10; i++) begin step(1'b0, 1'b1, 1'b0); if (X !== 1'b0) seen = 1; end
        check("pulse_no_X", seen, 32'd0);
        check("pulse_no_count", {24'b0, veh_count}, 32'd0);

        phase = "glitch";
        do_clear();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 2; i++) begin step(1'b0, 1'b1, 1'b0); if (X !== 1'b1) seen = 1; end
        for (int i = 0; i < 10; i++) begin step(1'b1, 1'b1, 1'b0); if (X !== 1'b1) seen = 1; end
        check("glitch_X_held", seen, 32'd0);
        check("glitch_count", {24'b0, veh_count}, 32'd1);

        phase = "rearrive";
        do_clear();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 9; i++) begin step(1'b0, 1'b1, 1'b0); if (X !== 1'b1) seen = 1; end
        for (int i = 0; i < 10; i++) begin step(1'b1, 1'b1, 1'b0); if (X !== 1'b1) seen = 1; end
        check("rearrive_X_held", seen, 32'd0);
        check("rearrive_count", {24'b0, veh_count}, 32'd2);
        first = -1;
        for (int i = 1; i <= 30; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (first < 0 && X === 1'b0) first = i;
        end
        check("rearrive_fall", first, 32'd14);

        phase = "enable_fault";
        do_clear();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("enable_forces_low", {31'b0, X}, 32'd0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        check("fault_set", {31'b0, fault}, 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        check("count_while_disabled", {24'b0, veh_count}, 32'd2);
        check("X_while_disabled", {31'b0, X}, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        check("fault_sticky", {31'b0, fault}, 32'd1);
        do_clear();
        check("fault_cleared", {31'b0, fault}, 32'd0);

        phase = "saturate";
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        end
        check("count_saturated", {24'b0, veh_count}, 32'd255);

        phase = "random";
        do_clear();
        lvl = 0;
        cyc = 0;
        while (cyc < 2000) begin
            run = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 7);
            lvl = 1 - lvl;
            for (int i = 0; i < run; i++) begin
                step(lvl[0], ($urandom_range(0, 7) != 0), ($urandom_range(0, 299) == 0));
                cyc++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
